regfile_cmd_seq: RTL and testbench

- Front-end command sequencer that sits directly upstream of the 16x4 register file.
- Turns one raw push button, a mode switch and 4 data switches into the register file's load strobes (push1..push4), its shared 4-bit `no` bus and the `wenable` write strobe.
- Debounces the button, detects presses and walks an FSM through a complete read or write transaction, one field per press.

---
 rtl/regfile_cmd_seq.sv | 138 +++++++++++++
 tb/tb_regfile_cmd_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_cmd_seq.sv
// Push-button command sequencer for the 16x4 register file.
// One debounced press per field; write transactions end with a commit strobe.
module regfile_cmd_seq #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       mode,
    input  logic [3:0] sw,
    output logic [3:0] no,
    output logic       push1,
    output logic       push2,
    output logic       push3,
    output logic       push4,
    output logic       wenable,
    output logic       busy,
    output logic [1:0] phase,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD2    = 2'd1,
        S_WR2    = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [1:0]       warm;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             level_d;
    logic             armed;
    logic             press;
    state_t           state;

    // warm marks when s2 holds a real sample, so a button held
    // through reset cannot arm the press detector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            warm    <= 2'b00;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            armed   <= 1'b0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            warm    <= {warm[0], 1'b1};
            level_d <= level;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (!level && !s2 && warm[1]) begin
                armed <= 1'b1;
            end
        end
    end

    assign press = armed & level & ~level_d;
    assign phase = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            no      <= 4'd0;
            push1   <= 1'b0;
            push2   <= 1'b0;
            push3   <= 1'b0;
            push4   <= 1'b0;
            wenable <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            push1   <= 1'b0;
            push2   <= 1'b0;
            push3   <= 1'b0;
            push4   <= 1'b0;
            wenable <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (press) begin
                        no   <= sw;
                        busy <= 1'b1;
                        if (mode) begin
                            push3 <= 1'b1;
                            state <= S_WR2;
                        end else begin
                            push1 <= 1'b1;
                            state <= S_RD2;
                        end
                    end
                end
                S_RD2: begin
                    if (press) begin
                        no    <= sw;
                        push2 <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_WR2: begin
                    if (press) begin
                        no    <= sw;
                        push4 <= 1'b1;
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    // two cycles here: the push4 cycle, then the commit
                    if (!wenable) begin
                        wenable <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_cmd_seq.sv
// Directed bench for regfile_cmd_seq: latency, read/write flows,
// bounce rejection, reset corner cases and dropped commit presses.
module tb_regfile_cmd_seq;

    localparam int DB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] sw = 4'd0;
    logic [3:0] no;
    logic       push1;
    logic       push2;
    logic       push3;
    logic       push4;
    logic       wenable;
    logic       busy;
    logic [1:0] phase;
    logic       done;

    int errors = 0;
    int checks = 0;
    int n_p1 = 0;
    int n_p2 = 0;
    int n_p3 = 0;
    int n_p4 = 0;
    int n_wen = 0;
    int viol = 0;

    regfile_cmd_seq #(.DEBOUNCE_CYCLES(DB), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .mode(mode), .sw(sw),
        .no(no), .push1(push1), .push2(push2), .push3(push3),
        .push4(push4), .wenable(wenable), .busy(busy),
        .phase(phase), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (push1) n_p1++;
        if (push2) n_p2++;
        if (push3) n_p3++;
        if (push4) n_p4++;
        if (wenable) n_wen++;
        if ((32'(push1) + 32'(push2) + 32'(push3) + 32'(push4)) > 1) viol++;
        if (wenable && (push1 || push2 || push3 || push4)) viol++;
        if (wenable && phase != 2'd3) viol++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] strb();
        return {push4, push3, push2, push1};
    endfunction

    function automatic int npush();
        return n_p1 + n_p2 + n_p3 + n_p4;
    endfunction

    task automatic do_reset(input logic b);
        btn = b;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // returns at the negedge where a strobe is first seen
    task automatic press(input logic [3:0] s, output int lat);
        sw = s;
        btn = 1'b1;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (push1 || push2 || push3 || push4) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_btn();
        btn = 1'b0;
        repeat (DB + 8) @(negedge clk);
    endtask

    initial begin
        int lat;
        int b3;
        int b4;
        int bw;
        int bp;

        @(negedge clk);
        check("reset_outs", 32'({no, push1, push2, push3, push4,
              wenable, done, busy, phase}), 32'd0);
        do_reset(1'b0);

        // write transaction
        b3 = n_p3; b4 = n_p4; bw = n_wen;
        mode = 1'b1;
        press(4'd3, lat);
        check("wr_latency", 32'(lat), 32'(DB + 2));
        check("wr_push3", 32'(strb()), 32'b0100);
        check("wr_addr_no", 32'(no), 32'd3);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_phase2", 32'(phase), 32'd2);
        release_btn();
        press(4'd9, lat);
        check("wr_push4", 32'(strb()), 32'b1000);
        check("wr_data_no", 32'(no), 32'd9);
        check("wr_no_early_wen", 32'(wenable), 32'd0);
        @(negedge clk);
        check("wr_commit", 32'({wenable, done}), 32'b11);
        check("wr_commit_strb", 32'(strb()), 32'd0);
        check("wr_commit_phase", 32'(phase), 32'd3);
        @(negedge clk);
        check("wr_after", 32'({wenable, done, busy, phase}), 32'd0);
        check("wr_no_hold", 32'(no), 32'd9);
        release_btn();
        check("wr_n_p3", 32'(n_p3 - b3), 32'd1);
        check("wr_n_p4", 32'(n_p4 - b4), 32'd1);
        check("wr_n_wen", 32'(n_wen - bw), 32'd1);

        // read transaction
        bw = n_wen;
        mode = 1'b0;
        press(4'd3, lat);
        check("rd_push1", 32'(strb()), 32'b0001);
        check("rd_addr1_no", 32'(no), 32'd3);
        check("rd_phase1", 32'(phase), 32'd1);
        release_btn();
        press(4'd5, lat);
        check("rd_push2", 32'(strb()), 32'b0010);
        check("rd_addr2_no", 32'(no), 32'd5);
        check("rd_done", 32'(done), 32'd1);
        @(negedge clk);
        check("rd_after", 32'({done, busy, phase}), 32'd0);
        release_btn();
        check("rd_no_wen", 32'(n_wen - bw), 32'd0);

        // bounce then hold, then an isolated glitch
        bp = npush();
        mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            btn = ((i / 3) % 2) == 0;
            @(negedge clk);
        end
        btn = 1'b1;
        repeat (40) @(negedge clk);
        check("bounce_one_push", 32'(npush() - bp), 32'd1);
        check("bounce_phase", 32'(phase), 32'd2);
        release_btn();
        btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_none", 32'(npush() - bp), 32'd1);

        // button held through reset release
        do_reset(1'b1);
        bp = npush();
        repeat (40) @(negedge clk);
        check("held_no_push", 32'(npush() - bp), 32'd0);
        check("held_phase", 32'(phase), 32'd0);
        release_btn();
        mode = 1'b0;
        press(4'd4, lat);
        check("held_then_push1", 32'(strb()), 32'b0001);
        check("held_latency", 32'(lat), 32'(DB + 2));
        release_btn();

        // reset mid write transaction
        do_reset(1'b0);
        bw = n_wen;
        mode = 1'b1;
        press(4'd7, lat);
        check("mid_push3", 32'(strb()), 32'b0100);
        release_btn();
        mode = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_mode_ignored", 32'(phase), 32'd2);
        btn = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("mid_busy_async", 32'({busy, phase}), 32'd0);
        repeat (3) @(negedge clk);
        btn = 1'b0;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("mid_idle", 32'(phase), 32'd0);
        check("mid_no_wen", 32'(n_wen - bw), 32'd0);

        // press injected during the commit is dropped
        bw = n_wen;
        b3 = n_p1 + n_p2;
        mode = 1'b1;
        press(4'd2, lat);
        release_btn();
        press(4'd8, lat);
        check("cm_push4", 32'(strb()), 32'b1000);
        force dut.level_d = 1'b0;
        @(negedge clk);
        check("cm_commit", 32'({wenable, done}), 32'b11);
        check("cm_commit_strb", 32'(strb()), 32'd0);
        release dut.level_d;
        @(negedge clk);
        check("cm_idle", 32'(phase), 32'd0);
        repeat (3) @(negedge clk);
        check("cm_dropped", 32'({phase, strb()}), 32'd0);
        check("cm_rd_none", 32'(n_p1 + n_p2 - b3), 32'd0);
        check("cm_wen_once", 32'(n_wen - bw), 32'd1);
        release_btn();
        mode = 1'b0;
        press(4'd6, lat);
        check("cm_next_push1", 32'(strb()), 32'b0001);
        check("cm_next_no", 32'(no), 32'd6);
        release_btn();

        check("invariants", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
